// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
//   Receive-side checker for VGA hs/vs timing. Measures line and frame
//   periods and sync widths against nominal values, tracks lock over
//   consecutive good frames, and regenerates pixel coordinates.
// Ports
//   clk           pixel clock
//   rst_n         asynchronous active-low reset
//   hs_in, vs_in  sync pins from the generator
//   clr_err       clears sticky h_err/v_err (a simultaneous set wins)
//   locked        timing matched for LOCK_FRAMES consecutive frames
//   h_err, v_err  sticky line / frame timing error flags
//   h_total_meas  last measured clocks per line
//   v_total_meas  last measured lines per frame
//   px_x, px_y    regenerated pixel coordinates, 0 outside active area
//   px_active     locked and inside the active area
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_ARM    | waiting for the first hs edge and first vs edge
// ST_TRACK  | counting consecutive good frames in ok_cnt
// ST_LOCKED | LOCK_FRAMES good frames seen; any mismatch returns to TRACK
module vga_sync_monitor #(
   parameter int H_TOTAL         = 800,
   parameter int H_SYNC          = 96,
   parameter int H_BP            = 48,
   parameter int H_ACTIVE        = 640,
   parameter int V_TOTAL         = 525,
   parameter int V_SYNC          = 2,
   parameter int V_BP            = 33,
   parameter int V_ACTIVE        = 480,
   parameter bit SYNC_ACTIVE_LOW = 1'b1,
   parameter int LOCK_FRAMES     = 2,
   parameter int CW              = 11
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hs_in,
   input  logic          vs_in,
   input  logic          clr_err,
   output logic          locked,
   output logic          h_err,
   output logic          v_err,
   output logic [CW-1:0] h_total_meas,
   output logic [CW-1:0] v_total_meas,
   output logic [CW-1:0] px_x,
   output logic [CW-1:0] px_y,
   output logic          px_active
);

   localparam int OKW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES + 1) : 1;

   localparam logic [CW-1:0] C_MAX     = '1;
   localparam logic [CW-1:0] C_H_TOTAL = CW'(H_TOTAL);
   localparam logic [CW-1:0] C_H_SYNC  = CW'(H_SYNC);
   localparam logic [CW-1:0] C_V_TOTAL = CW'(V_TOTAL);
   localparam logic [CW-1:0] C_V_SYNC  = CW'(V_SYNC);
   localparam logic [CW-1:0] C_HX0     = CW'(H_SYNC + H_BP);
   localparam logic [CW-1:0] C_HX1     = CW'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [CW-1:0] C_VY0     = CW'(V_SYNC + V_BP);
   localparam logic [CW-1:0] C_VY1     = CW'(V_SYNC + V_BP + V_ACTIVE);

   typedef enum logic [1:0] {ST_ARM, ST_TRACK, ST_LOCKED} state_t;

   state_t         state, state_nxt;
   logic [OKW-1:0] ok_cnt, ok_nxt;
   logic           frame_bad, frame_bad_nxt;

   logic          hs_a, vs_a, hs_q, vs_q;
   logic          hs_edge, hs_fall, vs_edge, vs_fall;
   logic [CW-1:0] h_cnt, hs_w, v_cnt, vs_w;
   logic [CW-1:0] h_cnt_inc, v_meas_now;
   logic          h_armed, v_armed;
   logic          h_timeout, h_len_bad, h_wid_bad, v_len_bad, v_wid_bad;
   logic          h_mis, v_mis, any_mis;
   logic          h_in_act, v_in_act;

   assign hs_a    = hs_in ^ SYNC_ACTIVE_LOW;
   assign vs_a    = vs_in ^ SYNC_ACTIVE_LOW;
   assign hs_edge = hs_a & ~hs_q;
   assign hs_fall = ~hs_a & hs_q;
   assign vs_edge = vs_a & ~vs_q;
   assign vs_fall = ~vs_a & vs_q;

   // Saturating increments keep a dead sync from wrapping back into range.
   assign h_cnt_inc  = (h_cnt == C_MAX) ? C_MAX : h_cnt + CW'(1);
   // A coincident hs edge belongs to the frame that is ending.
   assign v_meas_now = (v_cnt == C_MAX) ? C_MAX : v_cnt + CW'(hs_edge);

   assign h_timeout = h_armed & ~hs_edge & (h_cnt == C_H_TOTAL);
   assign h_len_bad = hs_edge & h_armed & (h_cnt_inc != C_H_TOTAL);
   assign h_wid_bad = hs_fall & h_armed & (hs_w != C_H_SYNC);
   assign v_len_bad = vs_edge & v_armed & (v_meas_now != C_V_TOTAL);
   assign v_wid_bad = vs_fall & v_armed & (vs_w != C_V_SYNC);
   assign h_mis     = h_timeout | h_len_bad | h_wid_bad;
   assign v_mis     = v_len_bad | v_wid_bad;
   assign any_mis   = h_mis | v_mis;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_q         <= 1'b0;
         vs_q         <= 1'b0;
         h_cnt        <= '0;
         h_armed      <= 1'b0;
         hs_w         <= '0;
         v_cnt        <= '0;
         v_armed      <= 1'b0;
         vs_w         <= '0;
         h_total_meas <= '0;
         v_total_meas <= '0;
         h_err        <= 1'b0;
         v_err        <= 1'b0;
      end else begin
         hs_q  <= hs_a;
         vs_q  <= vs_a;
         h_cnt <= hs_edge ? '0 : h_cnt_inc;
         if (hs_edge) begin
            h_armed <= 1'b1;
         end
         if (hs_edge) begin
            hs_w <= CW'(1);
         end else if (hs_a && hs_w != C_MAX) begin
            hs_w <= hs_w + CW'(1);
         end
         if (hs_edge && h_armed) begin
            h_total_meas <= h_cnt_inc;
         end
         if (vs_edge) begin
            v_cnt   <= '0;
            v_armed <= 1'b1;
            if (v_armed) begin
               v_total_meas <= v_meas_now;
            end
         end else if (hs_edge && v_cnt != C_MAX) begin
            v_cnt <= v_cnt + CW'(1);
         end
         if (vs_edge) begin
            vs_w <= CW'(hs_edge);
         end else if (vs_a && hs_edge && vs_w != C_MAX) begin
            vs_w <= vs_w + CW'(1);
         end
         h_err <= h_mis | (h_err & ~clr_err);
         v_err <= v_mis | (v_err & ~clr_err);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_ARM;
         ok_cnt    <= '0;
         frame_bad <= 1'b0;
      end else begin
         state     <= state_nxt;
         ok_cnt    <= ok_nxt;
         frame_bad <= frame_bad_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      ok_nxt        = ok_cnt;
      frame_bad_nxt = frame_bad;
      case (state)
         ST_ARM: begin
            if ((h_armed | hs_edge) && (v_armed | vs_edge)) begin
               state_nxt     = ST_TRACK;
               ok_nxt        = '0;
               frame_bad_nxt = 1'b0;
            end
         end
         ST_TRACK, ST_LOCKED: begin
            if (vs_edge) begin
               // Mismatches seen at the vs edge belong to the ending frame.
               frame_bad_nxt = 1'b0;
               if (any_mis || frame_bad) begin
                  state_nxt = ST_TRACK;
                  ok_nxt    = '0;
               end else if (state == ST_TRACK) begin
                  if (ok_cnt + OKW'(1) == OKW'(LOCK_FRAMES)) begin
                     state_nxt = ST_LOCKED;
                  end
                  ok_nxt = ok_cnt + OKW'(1);
               end
            end else if (any_mis) begin
               state_nxt     = ST_TRACK;
               ok_nxt        = '0;
               frame_bad_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt = ST_ARM;
            ok_nxt    = '0;
         end
      endcase
   end

   assign locked    = (state == ST_LOCKED);
   assign h_in_act  = (h_cnt >= C_HX0) && (h_cnt < C_HX1);
   assign v_in_act  = (v_cnt >= C_VY0) && (v_cnt < C_VY1);
   assign px_active = locked & h_in_act & v_in_act;
   assign px_x      = px_active ? h_cnt - C_HX0 : '0;
   assign px_y      = px_active ? v_cnt - C_VY0 : '0;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor. Timing is scaled down (40 clocks
// per line, 20 lines per frame) so many frames fit in a short run; the
// relationships between sync, porch and active regions are preserved.
module tb_vga_sync_monitor;

   localparam int H_T = 40, H_S = 4, H_B = 6, H_A = 24;
   localparam int V_T = 20, V_S = 2, V_B = 3, V_A = 12;
   localparam int CW  = 11;

   localparam int SG_LOCKED = 0, SG_HERR = 1, SG_VERR = 2, SG_HMEAS = 3;
   localparam int SG_VMEAS = 4, SG_PX = 5, SG_PY = 6, SG_PACT = 7;
   localparam int SG_ACTCNT = 8, SG_XMAX = 9, SG_YMAX = 10, SG_PXBAD = 11;
   localparam int SG_LOCKSEEN = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          hs_in = 1'b1;
   logic          vs_in = 1'b1;
   logic          clr_err = 1'b0;
   logic          locked, h_err, v_err, px_active;
   logic [CW-1:0] h_total_meas, v_total_meas, px_x, px_y;

   vga_sync_monitor #(
      .H_TOTAL(H_T), .H_SYNC(H_S), .H_BP(H_B), .H_ACTIVE(H_A),
      .V_TOTAL(V_T), .V_SYNC(V_S), .V_BP(V_B), .V_ACTIVE(V_A),
      .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2), .CW(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .hs_in(hs_in), .vs_in(vs_in),
      .clr_err(clr_err), .locked(locked), .h_err(h_err), .v_err(v_err),
      .h_total_meas(h_total_meas), .v_total_meas(v_total_meas),
      .px_x(px_x), .px_y(px_y), .px_active(px_active)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int    cyc;
      int    sig;
      int    ev;
      string name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   bit scan_on = 0, scan_prev = 0, lock_win = 0, lock_prev = 0;
   int act_cnt = 0, xmax = 0, ymax = 0, pxbad = 0, lock_seen = 0;
   exp_t mon_e;
   int   mon_act;

   // Insert keeping the queue ordered by target cycle.
   task automatic push_exp(input int at, input int sig, input int ev, input string nm);
      exp_t e;
      int   i;
      e.cyc  = at;
      e.sig  = sig;
      e.ev   = ev;
      e.name = nm;
      i = sb.size();
      while (i > 0 && sb[i-1].cyc > at) i--;
      sb.insert(i, e);
   endtask

   function automatic int sample(input int sig);
      case (sig)
         SG_LOCKED:   return int'(locked);
         SG_HERR:     return int'(h_err);
         SG_VERR:     return int'(v_err);
         SG_HMEAS:    return int'(h_total_meas);
         SG_VMEAS:    return int'(v_total_meas);
         SG_PX:       return int'(px_x);
         SG_PY:       return int'(px_y);
         SG_PACT:     return int'(px_active);
         SG_ACTCNT:   return act_cnt;
         SG_XMAX:     return xmax;
         SG_YMAX:     return ymax;
         SG_PXBAD:    return pxbad;
         SG_LOCKSEEN: return lock_seen;
         default:     return -1;
      endcase
   endfunction

   always @(negedge clk) begin
      if (scan_on && !scan_prev) begin
         act_cnt = 0;
         xmax    = 0;
         ymax    = 0;
         pxbad   = 0;
      end
      scan_prev = scan_on;
      if (scan_on) begin
         if (px_active) begin
            act_cnt++;
            if (int'(px_x) > xmax) xmax = int'(px_x);
            if (int'(px_y) > ymax) ymax = int'(px_y);
         end else if (px_x != '0 || px_y != '0) begin
            pxbad++;
         end
      end
      if (lock_win && !lock_prev) lock_seen = 0;
      lock_prev = lock_win;
      if (lock_win && locked) lock_seen = 1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e = sb.pop_front();
         checks++;
         if (mon_e.cyc < cyc) begin
            errors++;
            $display("FAIL %s: check for cycle %0d was not sampled (now %0d)",
                     mon_e.name, mon_e.cyc, cyc);
         end else begin
            mon_act = sample(mon_e.sig);
            if (mon_act != mon_e.ev) begin
               errors++;
               $display("FAIL %s @cycle %0d: got %0d, expected %0d",
                        mon_e.name, cyc, mon_act, mon_e.ev);
            end
         end
      end
   end

   function automatic logic pin(input logic asserted, input logic inv);
      return inv ? asserted : ~asserted;
   endfunction

   task automatic idle(input int n, input logic inv);
      repeat (n) begin
         @(posedge clk); #1;
         hs_in   = pin(1'b0, inv);
         vs_in   = pin(1'b0, inv);
         clr_err = 1'b0;
      end
   endtask

   task automatic do_reset(input logic inv);
      @(posedge clk); #1;
      rst_n = 1'b0;
      idle(3, inv);
      rst_n = 1'b1;
      idle(4, inv);
   endtask

   // One frame: vs asserted together with the hs of line 0.
   task automatic run_frame(input int stretch_line, input logic inv,
                            input int clr_line, input int rst_line);
      for (int ln = 0; ln < V_T; ln++) begin
         int len;
         len = (ln == stretch_line) ? H_T + 1 : H_T;
         for (int c = 0; c < len; c++) begin
            @(posedge clk); #1;
            hs_in   = pin(c < H_S, inv);
            vs_in   = pin(ln < V_S, inv);
            clr_err = (ln == clr_line) && (c == 0);
            if (ln == rst_line && c == 3) rst_n = 1'b0;
            if (ln == rst_line && c == 5) rst_n = 1'b1;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks pending", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int f, l, e, s, r, c;

      // Reset state
      rst_n = 1'b0;
      idle(3, 1'b0);
      push_exp(cyc, SG_LOCKED, 0, "rst_locked");
      push_exp(cyc, SG_HERR,   0, "rst_h_err");
      push_exp(cyc, SG_VERR,   0, "rst_v_err");
      push_exp(cyc, SG_HMEAS,  0, "rst_h_meas");
      push_exp(cyc, SG_VMEAS,  0, "rst_v_meas");
      push_exp(cyc, SG_PX,     0, "rst_px_x");
      push_exp(cyc, SG_PY,     0, "rst_px_y");
      push_exp(cyc, SG_PACT,   0, "rst_px_active");
      idle(1, 1'b0);
      rst_n = 1'b1;
      idle(4, 1'b0);

      // Nominal lock: locked one clock after the third vs edge
      run_frame(-1, 1'b0, -1, -1);
      run_frame(-1, 1'b0, -1, -1);
      f = cyc + 1;
      push_exp(f,     SG_LOCKED, 0,   "t1_locked_at_vs3");
      push_exp(f + 1, SG_LOCKED, 1,   "t1_locked_after_vs3");
      push_exp(f + 1, SG_HMEAS,  H_T, "t1_h_meas");
      push_exp(f + 1, SG_VMEAS,  V_T, "t1_v_meas");
      push_exp(f + 1, SG_HERR,   0,   "t1_h_err");
      push_exp(f + 1, SG_VERR,   0,   "t1_v_err");

      // Pixel regeneration over one locked frame
      l = f + (V_S + V_B) * H_T;
      push_exp(l + H_S + H_B,           SG_PACT, 0,       "t2_pre_first_px");
      push_exp(l + 1 + H_S + H_B,       SG_PACT, 1,       "t2_first_px_active");
      push_exp(l + 1 + H_S + H_B,       SG_PX,   0,       "t2_first_px_x");
      push_exp(l + 1 + H_S + H_B,       SG_PY,   0,       "t2_first_px_y");
      push_exp(l + H_S + H_B + H_A,     SG_PX,   H_A - 1, "t2_line_last_px_x");
      push_exp(l + 1 + H_S + H_B + H_A, SG_PACT, 0,       "t2_front_porch");
      l = f + (V_S + V_B + V_A - 1) * H_T;
      push_exp(l + H_S + H_B + H_A,     SG_PX,   H_A - 1, "t2_frame_last_px_x");
      push_exp(l + H_S + H_B + H_A,     SG_PY,   V_A - 1, "t2_frame_last_px_y");
      scan_on = 1'b1;
      run_frame(-1, 1'b0, -1, -1);
      scan_on = 1'b0;
      push_exp(cyc, SG_ACTCNT, H_A * V_A, "t2_active_count");
      push_exp(cyc, SG_XMAX,   H_A - 1,   "t2_px_x_max");
      push_exp(cyc, SG_YMAX,   V_A - 1,   "t2_px_y_max");
      push_exp(cyc, SG_PXBAD,  0,         "t2_px_zero_outside");

      // One line stretched by a clock, then relock after two good frames
      f = cyc + 1;
      e = f + 8 * H_T + 1;
      push_exp(e,     SG_LOCKED, 1,       "t3_locked_before");
      push_exp(e + 1, SG_LOCKED, 0,       "t3_locked_drop");
      push_exp(e + 1, SG_HMEAS,  H_T + 1, "t3_h_meas_long");
      push_exp(e + 1, SG_HERR,   1,       "t3_h_err_set");
      run_frame(7, 1'b0, -1, -1);
      f = cyc + 1;
      push_exp(f + 1, SG_LOCKED, 0, "t3_bad_frame_no_lock");
      run_frame(-1, 1'b0, -1, -1);
      f = cyc + 1;
      push_exp(f + 1, SG_LOCKED, 0, "t3_one_good_frame");
      run_frame(-1, 1'b0, -1, -1);
      f = cyc + 1;
      push_exp(f + 1, SG_LOCKED, 1,   "t3_relocked");
      push_exp(f + 1, SG_HERR,   1,   "t3_h_err_sticky");
      push_exp(f + 1, SG_HMEAS,  H_T, "t3_h_meas_nominal");
      c = f + 3 * H_T;
      push_exp(c + 1, SG_HERR, 0, "t3_clr_err");

      // Dead hs after the last line: timeout at h_cnt == H_TOTAL
      s = f + (V_T - 1) * H_T;
      push_exp(s + H_T + 1, SG_HERR,   0,   "t4_h_err_before_timeout");
      push_exp(s + H_T + 1, SG_LOCKED, 1,   "t4_locked_before_timeout");
      push_exp(s + H_T + 2, SG_HERR,   1,   "t4_timeout_h_err");
      push_exp(s + H_T + 2, SG_LOCKED, 0,   "t4_timeout_unlock");
      push_exp(s + H_T + 2, SG_VMEAS,  V_T, "t4_v_meas_kept");
      run_frame(-1, 1'b0, 3, -1);
      idle(2 * H_T, 1'b0);

      // Inverted sync polarity never locks
      do_reset(1'b1);
      lock_win = 1'b1;
      repeat (4) run_frame(-1, 1'b1, -1, -1);
      lock_win = 1'b0;
      push_exp(cyc, SG_LOCKSEEN, 0, "t5_never_locked");
      push_exp(cyc, SG_HERR,     1, "t5_h_err");
      push_exp(cyc, SG_VERR,     1, "t5_v_err");

      // Reset mid-frame, re-arm, relock, then clear racing a new mismatch
      do_reset(1'b0);
      run_frame(-1, 1'b0, -1, -1);
      run_frame(-1, 1'b0, -1, -1);
      f = cyc + 1;
      push_exp(f + 1, SG_LOCKED, 1, "t6_locked_first");
      run_frame(-1, 1'b0, -1, -1);
      f = cyc + 1;
      r = f + 8 * H_T + 3;
      push_exp(r - 1, SG_LOCKED, 1,   "t6_locked_pre_rst");
      push_exp(r - 1, SG_HMEAS,  H_T, "t6_h_meas_pre_rst");
      push_exp(r,     SG_LOCKED, 0,   "t6_rst_locked");
      push_exp(r,     SG_HMEAS,  0,   "t6_rst_h_meas");
      push_exp(r,     SG_VMEAS,  0,   "t6_rst_v_meas");
      push_exp(r,     SG_HERR,   0,   "t6_rst_h_err");
      run_frame(-1, 1'b0, -1, 8);
      f = cyc + 1;
      push_exp(f + 1, SG_LOCKED, 0, "t6_arm_frame");
      run_frame(-1, 1'b0, -1, -1);
      f = cyc + 1;
      push_exp(f + 1, SG_LOCKED, 0, "t6_one_good_frame");
      run_frame(-1, 1'b0, -1, -1);
      f = cyc + 1;
      push_exp(f + 1, SG_LOCKED, 1, "t6_relocked");
      e = f + 8 * H_T + 1;
      push_exp(e,     SG_HERR,  0,       "t6_h_err_before_race");
      push_exp(e + 1, SG_HERR,  1,       "t6_set_beats_clear");
      push_exp(e + 1, SG_HMEAS, H_T + 1, "t6_h_meas_long");
      run_frame(7, 1'b0, 8, -1);
      idle(5, 1'b0);

      if (sb.size() != 0) begin
         $display("FAIL pending_checks: %0d left, required 0", sb.size());
         errors += sb.size();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
